// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and constants for the frequency/period meter
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    GATE  = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// rtl/freq_meter_sync_edge_detect.sv - two-flop synchronizer plus delay flop, rising-edge pulse
module sync_edge_detect
  import freq_meter_pkg::*;
(
  input  logic clk_in,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  // sync_q[0] is s1, sync_q[SYNC_STAGES-1] is s2; s3 holds the previous s2
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s3;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s3     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s3     <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~s3;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts rising edges per gate window and reference cycles between edges
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int NBITS           = 32,
  parameter int REFERENCE_CLOCK = 50_000_000,
  parameter int GATE_CYCLES     = REFERENCE_CLOCK
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [NBITS-1:0] freq_out,
  output logic [NBITS-1:0] period_out,
  output logic             valid,
  output logic             overflow
);

  localparam logic [NBITS-1:0] ALL_ONES  = '1;
  localparam logic [NBITS-1:0] GATE_LAST = NBITS'(GATE_CYCLES - 1);
  localparam logic [NBITS-1:0] ONE       = NBITS'(1);

  logic             rise;
  state_t           state, state_nxt;
  logic [NBITS-1:0] gate_cnt, edge_cnt, per_cnt;
  logic [NBITS-1:0] edge_val;
  logic             edge_sat, per_sat, window_end;

  sync_edge_detect u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ALIGN;
      ALIGN:   if (rise)   state_nxt = GATE;
      GATE:    state_nxt = GATE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // a rise in the closing cycle still belongs to the window being reported
  always_comb begin
    edge_sat   = (edge_cnt == ALL_ONES);
    per_sat    = (per_cnt == ALL_ONES);
    edge_val   = (rise && !edge_sat) ? edge_cnt + ONE : edge_cnt;
    window_end = (state == GATE) && enable && (gate_cnt == GATE_LAST);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      per_cnt    <= '0;
      freq_out   <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable || state == IDLE) begin
        // partial window is dropped; published results keep their values
        gate_cnt <= '0;
        edge_cnt <= '0;
        per_cnt  <= '0;
        overflow <= 1'b0;
      end else if (state == ALIGN) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        if (rise) per_cnt <= ONE;
      end else begin
        if (rise) begin
          period_out <= per_cnt;
          per_cnt    <= ONE;
        end else if (!per_sat) begin
          per_cnt <= per_cnt + ONE;
        end

        if (window_end) begin
          freq_out <= edge_val;
          valid    <= 1'b1;
          gate_cnt <= '0;
          edge_cnt <= '0;
        end else begin
          gate_cnt <= gate_cnt + ONE;
          edge_cnt <= edge_val;
        end

        if ((!rise && per_sat) || (rise && edge_sat)) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed scoreboard bench for freq_meter
module tb_freq_meter;
  import freq_meter_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, sig_in, enable4, sig4;
  logic [31:0] freq_out, period_out;
  logic        valid, overflow;
  logic [3:0]  freq4, period4;
  logic        valid4, overflow4;

  typedef struct {
    logic [31:0] freq;
    logic [31:0] period;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_cmp = 0, n_bad = 0, pops = 0, cyc = 0;
  int   hp = 0, ph = 0, t_align = 0, t_valid = 0;
  bit   arm = 1'b0, lat_wait = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  freq_meter #(.NBITS(32), .REFERENCE_CLOCK(50_000_000), .GATE_CYCLES(20)) dut (
    .clk_in(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_out(freq_out), .period_out(period_out), .valid(valid), .overflow(overflow)
  );

  freq_meter #(.NBITS(4), .REFERENCE_CLOCK(50_000_000), .GATE_CYCLES(10)) dut4 (
    .clk_in(clk), .reset(reset), .enable(enable4), .sig_in(sig4),
    .freq_out(freq4), .period_out(period4), .valid(valid4), .overflow(overflow4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input logic [31:0] f, input logic [31:0] p);
    exp_t e;
    e.freq   = f;
    e.period = p;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (hp != 0) begin
        ph++;
        if (ph >= hp) begin
          ph     = 0;
          sig_in = ~sig_in;
          if (sig_in && arm) begin
            t_align = cyc;
            arm     = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic wait_pops(input int nexp, input int budget, input string tag);
    int goal;
    int n;
    goal = pops + nexp;
    n    = 0;
    while (pops < goal && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 64'(pops >= goal), 1);
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (lat_wait) begin
        t_valid  = cyc;
        lat_wait = 1'b0;
      end
      chk("valid_expected", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        chk("freq_out", freq_out, e_mon.freq);
        chk("period_out", period_out, e_mon.period);
      end
      pops++;
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; sig_in = 1'b0; enable4 = 1'b0; sig4 = 1'b0;
    step(3);
    chk("rst_freq", freq_out, 0);
    chk("rst_period", period_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_state", dut.state, IDLE);
    reset = 1'b0;
    step(2);

    // steady input, period 10: two rises per 20-cycle window
    enable = 1'b1;
    step(2);
    chk("t2_state_align", dut.state, ALIGN);
    arm = 1'b1; lat_wait = 1'b1; ph = 0; hp = 5;
    push(3, 32'd2, 32'd10);
    wait_pops(3, 200, "t2_timeout");
    chk("t2_latency", 64'(t_valid - t_align), 23);

    // enable drop at gate cycle 7 after a lone aligning pulse
    enable = 1'b0; hp = 0; sig_in = 1'b0;
    step(5);
    enable = 1'b1;
    step(2);
    sig_in = 1'b1;
    step(10);
    chk("t6_state_gate", dut.state, GATE);
    chk("t6_gate_cnt", dut.gate_cnt, 7);
    enable = 1'b0;
    step(1);
    chk("t6_state_idle", dut.state, IDLE);
    chk("t6_gate_clr", dut.gate_cnt, 0);
    chk("t6_per_clr", dut.per_cnt, 0);
    chk("t6_ovf_clr", overflow, 0);
    sig_in = 1'b0;
    step(30);
    chk("t6_freq_hold", freq_out, 2);
    chk("t6_period_hold", period_out, 10);
    enable = 1'b1;
    step(1);
    chk("t6_realign", dut.state, ALIGN);
    step(5);
    chk("t6_still_align", dut.state, ALIGN);

    // period 20: every non-aligning rise lands on the last gate cycle
    ph = 0; hp = 10;
    push(2, 32'd1, 32'd20);
    wait_pops(2, 200, "t3_timeout");
    chk("t3_next_gate", dut.gate_cnt, 1);
    chk("t3_next_edge", dut.edge_cnt, 0);
    enable = 1'b0; hp = 0; sig_in = 1'b0;
    step(5);

    // no edges after alignment: zero count, period holds
    enable = 1'b1;
    step(2);
    sig_in = 1'b1;
    step(4);
    sig_in = 1'b0;
    push(2, 32'd0, 32'd20);
    wait_pops(2, 100, "t4_timeout");

    // asynchronous reset mid-window while toggling
    ph = 0; hp = 5;
    step(8);
    #3 reset = 1'b1;
    #1;
    chk("t1_freq", freq_out, 0);
    chk("t1_period", period_out, 0);
    chk("t1_valid", valid, 0);
    chk("t1_state", dut.state, IDLE);
    chk("t1_gate", dut.gate_cnt, 0);
    chk("t1_per", dut.per_cnt, 0);
    chk("t1_sync", {dut.u_sync.sync_q, dut.u_sync.s3}, 0);
    hp = 0; sig_in = 1'b0;
    step(3);
    reset = 1'b0;
    step(2);
    arm = 1'b1; lat_wait = 1'b1; ph = 0; hp = 5;
    push(1, 32'd2, 32'd10);
    wait_pops(1, 200, "t1_timeout");
    chk("t1_latency", 64'(t_valid - t_align), 23);
    enable = 1'b0; hp = 0; sig_in = 1'b0;
    step(3);

    // 4-bit instance: constant input after alignment saturates per_cnt
    enable4 = 1'b1;
    step(2);
    sig4 = 1'b1;
    step(10);
    chk("t5_ovf_early", overflow4, 0);
    step(20);
    chk("t5_per_sat", dut4.per_cnt, 15);
    chk("t5_ovf_set", overflow4, 1);
    chk("t5_freq", freq4, 0);
    enable4 = 1'b0;
    step(1);
    chk("t5_ovf_clr", overflow4, 0);

    step(2);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
